fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of stage_one in the 3-stage core.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake, with at most one request outstanding.
- Buffers returned instructions in a small prefetch FIFO and presents them to stage_one with their PC.
- Honours stage_one stall, branch/jump redirect with flush, and sticky system halt.

Parameters:
- DW, 16, instruction/data word width (matches uword).
- AW, 16, PC / instruction address width.
- DEPTH, 2, prefetch FIFO entries (power of two, >=2).
- PC_STEP, 2, PC increment per instruction (byte-addressed).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  stage_one cannot accept; hold the head entry.
- halt_sys  in  1  halt request; sticky once sampled high.
- redirect_en  in  1  taken branch/jump: flush and refetch.
- redirect_pc  in  AW  target PC for redirect_en.
- imem_req  out  1  read request valid.
- imem_addr  out  AW  read address; stable while imem_req is high and not acked.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  DW  returned instruction word.
- out_valid  out  1  out_instr/out_pc are valid.
- out_instr  out  DW  instruction to stage_one (FIFO head).
- out_pc  out  AW  PC of out_instr.
- halted  out  1  fetch has stopped because of halt.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, FIFO empty, state=RUN, imem_req=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- States:
  - RUN: no request outstanding.
  - WAIT: request outstanding.
  - DRAIN: request outstanding; its response will be discarded.
  - HALT: terminal until reset.
- Issue rule:
  - In RUN, when count + 0 < DEPTH and no halt/redirect this cycle: assert imem_req with imem_addr=fetch_pc and go to WAIT.
  - imem_req stays high until the ack cycle; it is combinational from state.
- WAIT + imem_ack:
  - Push {imem_rdata, imem_addr} into the FIFO.
  - fetch_pc += PC_STEP, wrapping modulo 2^AW (0xFFFE -> 0x0000).
  - Go to RUN. The next request may issue on the following cycle, so peak throughput is one instruction per 2 cycles.
- DRAIN + imem_ack: drop the data, leave fetch_pc unchanged, go to RUN.
- Pop rule:
  - out_valid = FIFO non-empty and state != HALT.
  - Pop when out_valid && !stall.
  - Push and pop in the same cycle is legal; count is unchanged.
- Redirect (highest priority after reset):
  - FIFO is flushed (count=0) and out_valid is 0 the next cycle.
  - fetch_pc = redirect_pc.
  - From WAIT without ack: go to DRAIN.
  - From WAIT with ack in the same cycle: discard that data and go to RUN.
  - From DRAIN: stay in DRAIN.
  - redirect_pc is forced to PC_STEP alignment by clearing its low bits.
- Stall: blocks pops only. Fetching continues until the FIFO is full. Redirect overrides stall.
- Halt:
  - halt_sys high sets a sticky halt.
  - No new requests issue.
  - An outstanding request is allowed to complete and its data is discarded; the block then enters HALT.
  - In HALT: halted=1, out_valid=0. Redirect is ignored. Only rst exits.
- Full: with count==DEPTH no request issues. A pop in that cycle frees space for issue on the next cycle; no same-cycle bypass.
- Reset mid-request: the request is abandoned; the memory side must tolerate imem_req dropping without ack.

Decomposition:
- Shared in types_pkg:
  - fetch_state_e {RUN, WAIT, DRAIN, HALT}.
  - fetch_entry_t struct {instr, pc}.
  - RESET_PC constant.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO.
  - Ports: push, pop, flush, full, empty, head.
  - Async active-low reset.
  - Simultaneous push+pop at full is legal when pop occurs.
  - flush beats push.

Test Plan:
1. Reset release, memory acks 1 cycle after each req, no stall: imem_addr sequence 0x0000, 0x0002, 0x0004; out_pc follows the same sequence with out_valid pulsing every 2 cycles.
2. Hold stall=1 for 10 cycles: exactly DEPTH=2 requests issue, then imem_req stays 0. Release stall: out_pc 0x0000 then 0x0002 on consecutive cycles, then fetch resumes at 0x0004.
3. redirect_en with redirect_pc=0x0040 while in WAIT, ack arrives 3 cycles later with data 0xDEAD: 0xDEAD never appears on out_instr; next imem_addr is 0x0040.
4. redirect_en and imem_ack in the same cycle: acked data dropped, FIFO empty, next request goes to redirect_pc with no DRAIN cycle.
5. Start at fetch_pc 0xFFFE: the next request after the ack is at 0x0000; out_pc shows 0xFFFE then 0x0000.
6. halt_sys pulse during WAIT: no further requests after the ack; halted=1 and out_valid=0 permanently. Assert rst=0 mid-halt: all outputs go to reset values immediately, and fetch restarts at 0x0000 after release.

Source files
------------

// File: rtl/types_pkg.sv
// types_pkg: shared fetch-stage widths, reset PC, FSM states and FIFO entry type
package types_pkg;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam logic [AW-1:0] RESET_PC = '0;
  typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} fetch_state_e;
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem req/addr/ack/rdata bus plus out_valid/out_instr/out_pc to stage_one; master=fetch, slave=memory/stage_one
interface fetch_stage_if;
  import types_pkg::*;
  logic imem_req;
  logic [AW-1:0] imem_addr;
  logic imem_ack;
  logic [DW-1:0] imem_rdata;
  logic out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  modport master(
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input imem_ack, imem_rdata
  );
  modport slave(
    input imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO; ports clk, rst(async low), push, pop, flush (beats push), din, full, empty, head
module fetch_fifo import types_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wr, rd;
  logic do_push, do_pop;
  fetch_entry_t mem [DEPTH];
  assign empty = wr == rd;
  assign full = wr == {~rd[PW], rd[PW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd[PW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      rd <= wr;
    end else begin
      wr <= wr + (PW+1)'(do_push);
      rd <= rd + (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr[PW-1:0]] <= din;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one-at-a-time imem reads into a prefetch FIFO; ports clk, rst(async low), stall, halt_sys, redirect_en/pc, bus (imem + out), halted
module fetch_stage import types_pkg::*; #(
  parameter int            DEPTH    = 2,
  parameter int            PC_STEP  = 2,
  parameter logic [AW-1:0] RESET_PC = types_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          halt_sys,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  fetch_stage_if.master bus,
  output logic          halted
);
  fetch_state_e state;
  logic [AW-1:0] fetch_pc, req_addr, target;
  logic halt_q, halting, redir, push, pop, full, empty;
  fetch_entry_t din, head;
  assign halting = halt_sys || halt_q;
  assign redir = redirect_en && state != HALT;
  assign target = redirect_pc & ~AW'(PC_STEP - 1);
  assign push = state == WAIT && bus.imem_ack && !redirect_en && !halting;
  assign pop = bus.out_valid && !stall;
  assign din = '{instr: bus.imem_rdata, pc: req_addr};
  assign bus.imem_req = state == WAIT || state == DRAIN;
  assign bus.imem_addr = req_addr;
  assign bus.out_valid = !empty && state != HALT;
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_pc = bus.out_valid ? head.pc : '0;
  assign halted = state == HALT;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redir),
    .din(din),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      halt_q <= 1'b0;
    end else begin
      halt_q <= halting;
      if (redir) fetch_pc <= target;
      else if (push) fetch_pc <= fetch_pc + AW'(PC_STEP);
      case (state)
        RUN:
          if (halting) state <= HALT;
          else if (!redirect_en && !full) begin
            state <= WAIT;
            req_addr <= fetch_pc;
          end
        WAIT:
          if (bus.imem_ack) state <= halting ? HALT : RUN;
          else if (redirect_en || halting) state <= DRAIN;
        DRAIN:
          if (bus.imem_ack) state <= halting ? HALT : RUN;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed fetch_stage bench against a queue-based reference model
module tb_fetch_stage;
  import types_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 0, stall = 0, halt_sys = 0, redirect_en = 0, halted;
  logic [15:0] redirect_pc = '0;
  int checks = 0, failures = 0;
  fetch_stage_if bus();
  fetch_stage #(.DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .halt_sys(halt_sys),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .bus(bus),
    .halted(halted)
  );
  always #5 clk = ~clk;
  logic [15:0] m_q[$];
  logic [15:0] m_pc, m_addr;
  logic m_out, m_drop, m_hreq, m_halted;
  int rcnt, rlat, cyc;
  logic rand_lat, r_dead, req_prev, saw_dead;
  logic [15:0] req_log[$], pop_log[$];
  int pop_cyc[$];
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {1'b0, a[15:1] ^ 15'h2A5B};
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_pc = 16'h0000;
    m_addr = 16'h0000;
    m_out = 0;
    m_drop = 0;
    m_hreq = 0;
    m_halted = 0;
    rcnt = 0;
    req_prev = 0;
    r_dead = 0;
    saw_dead = 0;
    req_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    cyc = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    stall = 0;
    halt_sys = 0;
    redirect_en = 0;
    rand_lat = 0;
    bus.imem_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
  endtask
  task automatic tick();
    logic exp_v, hr, rd, acc;
    int n0;
    logic [15:0] tgt;
    if (bus.imem_req) begin
      if (!req_prev) begin
        req_log.push_back(bus.imem_addr);
        rcnt = 0;
      end
      bus.imem_ack = rcnt >= rlat;
      bus.imem_rdata = r_dead ? 16'hDEAD : mem_fn(bus.imem_addr);
      rcnt++;
      if (bus.imem_ack) begin
        r_dead = 0;
        if (rand_lat) rlat = $urandom_range(3, 0);
      end
    end else bus.imem_ack = 1'b0;
    req_prev = bus.imem_req;
    exp_v = m_q.size() > 0 && !m_halted;
    checks++;
    if (bus.imem_req !== m_out) begin
      failures++;
      $display("FAIL cyc%0d imem_req got %b want %b", cyc, bus.imem_req, m_out);
    end
    if (m_out) begin
      checks++;
      if (bus.imem_addr !== m_addr) begin
        failures++;
        $display("FAIL cyc%0d imem_addr got %h want %h", cyc, bus.imem_addr, m_addr);
      end
    end
    checks++;
    if (bus.out_valid !== exp_v) begin
      failures++;
      $display("FAIL cyc%0d out_valid got %b want %b", cyc, bus.out_valid, exp_v);
    end
    if (exp_v) begin
      checks += 2;
      if (bus.out_pc !== m_q[0]) begin
        failures++;
        $display("FAIL cyc%0d out_pc got %h want %h", cyc, bus.out_pc, m_q[0]);
      end
      if (bus.out_instr !== mem_fn(m_q[0])) begin
        failures++;
        $display("FAIL cyc%0d out_instr got %h want %h", cyc, bus.out_instr, mem_fn(m_q[0]));
      end
    end
    checks++;
    if (halted !== m_halted) begin
      failures++;
      $display("FAIL cyc%0d halted got %b want %b", cyc, halted, m_halted);
    end
    if (bus.out_valid && bus.out_instr == 16'hDEAD) saw_dead = 1;
    if (bus.out_valid && !stall) begin
      pop_log.push_back(bus.out_pc);
      pop_cyc.push_back(cyc);
    end
    n0 = m_q.size();
    hr = halt_sys || m_hreq;
    rd = redirect_en && !m_halted;
    tgt = redirect_pc & 16'hFFFE;
    acc = m_out && bus.imem_ack && !m_drop && !redirect_en && !hr;
    if (rd) m_q.delete();
    else if (n0 > 0 && !m_halted && !stall) void'(m_q.pop_front());
    if (acc) m_q.push_back(m_addr);
    if (!m_halted) begin
      if (!m_out) begin
        if (hr) m_halted = 1;
        else if (rd) m_pc = tgt;
        else if (n0 < DEPTH) begin
          m_out = 1;
          m_addr = m_pc;
          m_drop = 0;
        end
      end else begin
        if (rd) m_pc = tgt;
        if (bus.imem_ack) begin
          m_out = 0;
          if (acc) m_pc = m_pc + 16'd2;
          if (hr) m_halted = 1;
        end else if (rd || hr) m_drop = 1;
      end
    end
    m_hreq = m_hreq || halt_sys;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset imem_req got %b want 0", bus.imem_req); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    if (bus.out_instr !== 16'h0) begin failures++; $display("FAIL reset out_instr got %h want 0000", bus.out_instr); end
    if (bus.out_pc !== 16'h0) begin failures++; $display("FAIL reset out_pc got %h want 0000", bus.out_pc); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset halted got %b want 0", halted); end
  endtask
  task automatic test_sequential();
    do_reset();
    rlat = 0;
    repeat (10) tick();
    checks++;
    if (req_log.size() < 3 || pop_log.size() < 3) begin
      failures++;
      $display("FAIL seq counts got req=%0d pop=%0d want >=3", req_log.size(), pop_log.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (req_log[i] !== 16'(2 * i)) begin failures++; $display("FAIL seq req_addr[%0d] got %h want %h", i, req_log[i], 16'(2 * i)); end
        if (pop_log[i] !== 16'(2 * i)) begin failures++; $display("FAIL seq out_pc[%0d] got %h want %h", i, pop_log[i], 16'(2 * i)); end
        if (i > 0) begin
          checks++;
          if (pop_cyc[i] - pop_cyc[i-1] != 2) begin failures++; $display("FAIL seq pop_spacing[%0d] got %0d want 2", i, pop_cyc[i] - pop_cyc[i-1]); end
        end
      end
  endtask
  task automatic test_stall();
    do_reset();
    rlat = 0;
    stall = 1;
    repeat (10) tick();
    checks += 2;
    if (req_log.size() != DEPTH) begin failures++; $display("FAIL stall req_count got %0d want %0d", req_log.size(), DEPTH); end
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall imem_req got %b want 0", bus.imem_req); end
    stall = 0;
    repeat (6) tick();
    checks++;
    if (pop_log.size() < 2 || req_log.size() < 3) begin
      failures++;
      $display("FAIL stall_release counts got pop=%0d req=%0d want >=2/>=3", pop_log.size(), req_log.size());
    end else begin
      checks += 4;
      if (pop_log[0] !== 16'h0000) begin failures++; $display("FAIL stall_release pc0 got %h want 0000", pop_log[0]); end
      if (pop_log[1] !== 16'h0002) begin failures++; $display("FAIL stall_release pc1 got %h want 0002", pop_log[1]); end
      if (pop_cyc[1] - pop_cyc[0] != 1) begin failures++; $display("FAIL stall_release spacing got %0d want 1", pop_cyc[1] - pop_cyc[0]); end
      if (req_log[2] !== 16'h0004) begin failures++; $display("FAIL stall_release resume got %h want 0004", req_log[2]); end
    end
  endtask
  task automatic test_redirect_wait();
    do_reset();
    rlat = 3;
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    checks++;
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL redir_wait req_timeout got %b want 1", bus.imem_req); end
    redirect_en = 1;
    redirect_pc = 16'h0040;
    r_dead = 1;
    tick();
    redirect_en = 0;
    repeat (12) tick();
    checks += 2;
    if (saw_dead !== 1'b0) begin failures++; $display("FAIL redir_wait dead_seen got %b want 0", saw_dead); end
    if (req_log.size() < 2 || req_log[1] !== 16'h0040) begin
      failures++;
      $display("FAIL redir_wait next_addr got %h want 0040", req_log.size() < 2 ? 16'hxxxx : req_log[1]);
    end
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 16'h0040) begin
      failures++;
      $display("FAIL redir_wait first_out got %h want 0040", pop_log.size() < 1 ? 16'hxxxx : pop_log[0]);
    end
  endtask
  task automatic test_redirect_ack();
    do_reset();
    rlat = 0;
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    checks++;
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL redir_ack req_timeout got %b want 1", bus.imem_req); end
    redirect_en = 1;
    redirect_pc = 16'h0123;
    tick();
    redirect_en = 0;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_ack out_valid got %b want 0", bus.out_valid); end
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL redir_ack drain_cycle got %b want 0", bus.imem_req); end
    tick();
    checks += 2;
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL redir_ack reissue got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 16'h0122) begin failures++; $display("FAIL redir_ack addr got %h want 0122", bus.imem_addr); end
    repeat (4) tick();
  endtask
  task automatic test_wrap();
    do_reset();
    rlat = 0;
    redirect_en = 1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_en = 0;
    repeat (8) tick();
    checks++;
    if (req_log.size() < 2 || pop_log.size() < 2) begin
      failures++;
      $display("FAIL wrap counts got req=%0d pop=%0d want >=2", req_log.size(), pop_log.size());
    end else begin
      checks += 4;
      if (req_log[0] !== 16'hFFFE) begin failures++; $display("FAIL wrap req0 got %h want fffe", req_log[0]); end
      if (req_log[1] !== 16'h0000) begin failures++; $display("FAIL wrap req1 got %h want 0000", req_log[1]); end
      if (pop_log[0] !== 16'hFFFE) begin failures++; $display("FAIL wrap out0 got %h want fffe", pop_log[0]); end
      if (pop_log[1] !== 16'h0000) begin failures++; $display("FAIL wrap out1 got %h want 0000", pop_log[1]); end
    end
  endtask
  task automatic test_halt();
    do_reset();
    rlat = 2;
    stall = 1;
    for (int i = 0; i < 20 && req_log.size() < 2; i++) tick();
    checks++;
    if (req_log.size() != 2 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL halt setup got req=%0d want 2", req_log.size()); end
    halt_sys = 1;
    tick();
    halt_sys = 0;
    stall = 0;
    repeat (10) tick();
    checks += 3;
    if (req_log.size() != 2) begin failures++; $display("FAIL halt extra_req got %0d want 2", req_log.size()); end
    if (halted !== 1'b1) begin failures++; $display("FAIL halt halted got %b want 1", halted); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt out_valid got %b want 0", bus.out_valid); end
    #2 rst = 0;
    #1;
    checks += 5;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL halt_rst imem_req got %b want 0", bus.imem_req); end
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_rst halted got %b want 0", halted); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt_rst out_valid got %b want 0", bus.out_valid); end
    if (bus.out_pc !== 16'h0) begin failures++; $display("FAIL halt_rst out_pc got %h want 0000", bus.out_pc); end
    if (bus.out_instr !== 16'h0) begin failures++; $display("FAIL halt_rst out_instr got %h want 0000", bus.out_instr); end
    @(negedge clk);
    rst = 1;
    model_reset();
    repeat (4) tick();
    checks++;
    if (req_log.size() < 1 || req_log[0] !== 16'h0000) begin
      failures++;
      $display("FAIL halt_restart addr got %h want 0000", req_log.size() < 1 ? 16'hxxxx : req_log[0]);
    end
  endtask
  task automatic test_random();
    do_reset();
    rand_lat = 1;
    rlat = $urandom_range(3, 0);
    for (int i = 0; i < 600; i++) begin
      stall = $urandom_range(99, 0) < 30;
      redirect_en = $urandom_range(99, 0) < 6;
      redirect_pc = 16'($urandom);
      halt_sys = i > 520 && $urandom_range(99, 0) < 3;
      tick();
    end
    stall = 0;
    redirect_en = 0;
    halt_sys = 0;
    checks++;
    if (pop_log.size() < 50) begin failures++; $display("FAIL random progress got %0d want >=50", pop_log.size()); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.imem_ack = 0;
    bus.imem_rdata = '0;
    rlat = 0;
    rand_lat = 0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
